// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with wait states, byte-lane stores,
// sign/zero-extended loads and an alignment/type error response.
// busy_o covers the request cycle itself and every wait cycle, so the CPU
// holds its MEM stage until the cycle that carries ready_o.
module dmem_responder #(
   parameter int ADDR_W      = 7,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  dmtype_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        busy_o
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [2:0]         type_q, type_d;
   logic [ADDR_W+1:0]  addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               ready_q, ready_d, err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        mem [2**ADDR_W];
   logic               idle, accept, a_we, a_err, a_half, commit, wr_en;
   logic [2:0]         a_type;
   logic [ADDR_W+1:0]  a_addr;
   logic [ADDR_W-1:0]  idx;
   logic [31:0]        a_wdata, word, load_v, wr_data;
   logic [3:0]         wr_be;
   logic [7:0]         byte_v;
   logic [15:0]        half_v;
   logic               unused_addr;
   assign unused_addr = ^addr_i[31:ADDR_W+2];
   // access decode: in IDLE the live inputs are used so zero-wait and error
   // accesses can commit on the accept edge; afterwards the latched copies
   always_comb begin
      idle    = state_q == IDLE;
      accept  = idle && req_i;
      a_we    = idle ? we_i : we_q;
      a_type  = idle ? dmtype_i : type_q;
      a_addr  = idle ? addr_i[ADDR_W+1:0] : addr_q;
      a_wdata = idle ? wdata_i : wdata_q;
      a_half  = a_type == 3'd1 || a_type == 3'd2;
      a_err   = a_type > 3'd4 || (a_type == 3'd0 && a_addr[1:0] != 2'd0) || (a_half && a_addr[0]);
      idx     = a_addr[ADDR_W+1:2];
      word    = mem[idx];
      byte_v  = word[{a_addr[1:0], 3'b000} +: 8];
      half_v  = a_addr[1] ? word[31:16] : word[15:0];
      load_v  = a_type == 3'd0 ? word :
                a_type == 3'd1 ? {{16{half_v[15]}}, half_v} :
                a_type == 3'd2 ? {16'd0, half_v} :
                a_type == 3'd3 ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      commit  = (accept && (WAIT_CYCLES == 0 || a_err)) || (state_q == WAIT && cnt_q == 4'd0);
      wr_en   = commit && !a_err && a_we && rstn;
      wr_be   = a_type == 3'd0 ? 4'b1111 : a_half ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a_addr[1:0];
      wr_data = a_type == 3'd0 ? a_wdata : a_half ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
      ready_d = commit;
      err_d   = commit && a_err;
      rdata_d = (commit && !a_err && !a_we) ? load_v : 32'd0;
      state_d = state_q == RESP ? IDLE : commit ? RESP : accept ? WAIT : state_q;
      cnt_d   = accept ? 4'(WAIT_CYCLES - 1) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
      we_d    = accept ? we_i : we_q;
      type_d  = accept ? dmtype_i : type_q;
      addr_d  = accept ? addr_i[ADDR_W+1:0] : addr_q;
      wdata_d = accept ? wdata_i : wdata_q;
   end
   // FSM and registered response; reset aborts any access in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         type_q  <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
   // byte-lane store into the array on the commit edge; array is never reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (wr_en && wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
   end
   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;
   assign busy_o  = state_q == WAIT || accept;
endmodule
